// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader.
//   state_e            : loader FSM state encoding
//   IMEM_DEPTH_DEFAULT : default instruction-memory depth in 32-bit words
//   HDR_LEN            : length of the word-count header in bytes
// Optional feature macro used by the loader: IMEM_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   localparam int IMEM_DEPTH_DEFAULT = 1024;
   localparam int HDR_LEN            = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR0  = 3'd1,
      ST_HDR1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_WRITE = 3'd4,
      ST_CHK   = 3'd5,
      ST_DONE  = 3'd6
   } state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_byte_packer
// Assembles four consecutive bytes into a little-endian 32-bit word
// (first byte lands in word[7:0]).
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   clear      in  synchronous clear of the byte counter and shift register
//   byte_en    in  a byte is being accepted this cycle
//   byte_data  in  the byte being accepted
//   word_done  out high in the cycle the 4th byte of a word is accepted
//   word       out assembled word, valid while word_done is high
// -----------------------------------------------------------------------------
module imem_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic        word_done,
   output logic [31:0] word
);

   logic [1:0]  count_q, count_d;
   logic [31:0] shift_q, shift_d;

   // New bytes enter at the top and older bytes move down, so after four
   // bytes the first one sits in [7:0].
   assign word      = {byte_data, shift_q[31:8]};
   assign word_done = byte_en && (count_q == 2'd3);

   always_comb begin
      count_d = count_q;
      shift_d = shift_q;
      if (byte_en) begin
         count_d = count_q + 2'd1;
         shift_d = word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= 2'd0;
         shift_q <= 32'd0;
      end else begin
         count_q <= count_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads an instruction memory from a byte stream. Stream format:
//   N[7:0], N[15:8], then N*4 payload bytes (little-endian words),
//   then (checksum build only) one XOR checksum byte over the payload.
// The core is held in reset (cpu_rst) until the load has finished.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing checksum byte).
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   start      in  one-cycle pulse starting a load (from IDLE or DONE only)
//   byte_valid in  byte_data holds a valid byte
//   byte_data  in  stream byte
//   byte_ready out loader accepts a byte this cycle
//   we         out instruction-memory write strobe (one cycle per word)
//   wa         out word write address
//   wd         out write data word
//   busy       out load in progress
//   done       out load finished
//   err        out load failed (bad word count or checksum mismatch)
//   cpu_rst    out hold the core in reset
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH_DEFAULT,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          we,
   output logic [AW-1:0] wa,
   output logic [31:0]   wd,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          cpu_rst
);

   localparam int NW = 8 * HDR_LEN;   // width of the word-count field

   state_e          state_q, state_d;
   logic [7:0]      hdr_lo_q, hdr_lo_d;
   logic [NW-1:0]   n_last_q, n_last_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   wa_q, wa_d;
   logic [31:0]     wd_q, wd_d;
   logic            err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]      xor_q, xor_d;
`endif

   logic            byte_fire;
   logic            pack_clear;
   logic            pack_en;
   logic            word_done;
   logic [31:0]     word;
   logic [NW-1:0]   n_word;
   logic            n_bad;
   logic            last_word;

   assign byte_ready = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                       (state_q == ST_DATA) || (state_q == ST_CHK);
   assign byte_fire  = byte_valid && byte_ready;

   assign n_word     = {byte_data, hdr_lo_q};
   assign n_bad      = (n_word == '0) || ({1'b0, n_word} > (NW+1)'(DEPTH));
   assign last_word  = (NW'(idx_q) == n_last_q);

   // Packer restarts from an empty word whenever no load is running, so a
   // partial word from an aborted load can never leak into the next one.
   assign pack_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign pack_en    = byte_fire && (state_q == ST_DATA);

   imem_byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (pack_clear),
      .byte_en   (pack_en),
      .byte_data (byte_data),
      .word_done (word_done),
      .word      (word)
   );

   always_comb begin
      state_d  = state_q;
      hdr_lo_d = hdr_lo_q;
      n_last_d = n_last_q;
      idx_d    = idx_q;
      wa_d     = wa_q;
      wd_d     = wd_q;
      err_d    = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d    = xor_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_HDR0;
               err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d   = 8'd0;
`endif
            end
         end
         ST_HDR0: begin
            if (byte_fire) begin
               hdr_lo_d = byte_data;
               state_d  = ST_HDR1;
            end
         end
         ST_HDR1: begin
            if (byte_fire) begin
               if (n_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  n_last_d = n_word - NW'(1);
                  idx_d    = '0;
                  state_d  = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (byte_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d = xor_q ^ byte_data;
`endif
               // Address and data are only updated on entry to WRITE, so
               // they stay put for the whole time the strobe is low.
               if (word_done) begin
                  wd_d    = word;
                  wa_d    = idx_q;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = ST_CHK;
`else
               state_d = ST_DONE;
`endif
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = ST_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (byte_fire) begin
               if (byte_data != xor_q) begin
                  err_d = 1'b1;
               end
               state_d = ST_DONE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         hdr_lo_q <= 8'd0;
         n_last_q <= '0;
         idx_q    <= '0;
         wa_q     <= '0;
         wd_q     <= 32'd0;
         err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q    <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         hdr_lo_q <= hdr_lo_d;
         n_last_q <= n_last_d;
         idx_q    <= idx_d;
         wa_q     <= wa_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q    <= xor_d;
`endif
      end
   end

   assign we      = (state_q == ST_WRITE);
   assign wa      = wa_q;
   assign wd      = wd_q;
   assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done    = (state_q == ST_DONE);
   assign err     = err_q;
   assign cpu_rst = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Expected writes and error flag are
// computed from the byte stream by a reference model; a monitor captures
// every write strobe and watches address/data stability.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          we;
   logic [AW-1:0] wa;
   logic [31:0]   wd;
   logic          busy;
   logic          done;
   logic          err;
   logic          cpu_rst;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cpu_rst    (cpu_rst)
   );

   // ---------------- monitor ----------------
   logic [AW-1:0] got_a[$];
   logic [31:0]   got_d[$];
   int            ready_viol = 0;
   int            stab_viol  = 0;
   logic [AW-1:0] prev_wa;
   logic [31:0]   prev_wd;

   always @(posedge clk) begin
      #1;
      if (rst !== 1'b1) begin
         if (we === 1'b1) begin
            got_a.push_back(wa);
            got_d.push_back(wd);
            if (byte_ready !== 1'b0) ready_viol++;
         end else if (wa !== prev_wa || wd !== prev_wd) begin
            stab_viol++;
         end
      end
      prev_wa = wa;
      prev_wd = wd;
   end

   // ---------------- reference model ----------------
   logic [7:0]    stream[$];
   logic [AW-1:0] exp_a[$];
   logic [31:0]   exp_d[$];
   logic          exp_err;

   // Word count, validity, words and checksum straight from the stream format.
   task automatic model_expect();
      int n;
      logic [7:0] x;
      n = int'({stream[1], stream[0]});
      exp_a.delete();
      exp_d.delete();
      exp_err = 1'b0;
      if (n == 0 || n > DEPTH) begin
         exp_err = 1'b1;
      end else begin
         x = 8'd0;
         for (int i = 0; i < n; i++) begin
            exp_a.push_back(AW'(i));
            exp_d.push_back({stream[2+4*i+3], stream[2+4*i+2],
                             stream[2+4*i+1], stream[2+4*i]});
            for (int k = 0; k < 4; k++) x = x ^ stream[2+4*i+k];
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (stream[2+4*n] != x) exp_err = 1'b1;
`endif
      end
   endtask

   // Random stream of n words; bad_chk corrupts the checksum when present.
   task automatic make_stream(input int n, input bit bad_chk);
      logic [7:0] x;
      logic [7:0] b;
      stream.delete();
      stream.push_back(8'(n));
      stream.push_back(8'(n >> 8));
      x = 8'd0;
      for (int i = 0; i < 4*n; i++) begin
         b = 8'($urandom);
         x = x ^ b;
         stream.push_back(b);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(bad_chk ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
`else
      if (bad_chk) x = 8'd0;
`endif
   endtask

   // ---------------- drivers ----------------
   // Entered and left at a falling edge. While waiting, byte_valid stays high
   // so a byte taken while byte_ready is low would corrupt the result.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      int t;
      t  = 0;
      ok = 1'b1;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1) begin
         if (t == 200) begin
            checks++;
            failures++;
            $display("FAIL byte_ready_timeout got=%b want=1", byte_ready);
            ok = 1'b0;
            byte_valid = 1'b0;
            return;
         end
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s done_timeout got=%b want=1", name, done);
      end
   endtask

   // Runs the whole stream as one load and checks every observable result.
   task automatic run_load(input string name, input int max_gap, input bit poke_start);
      bit ok;
      got_a.delete();
      got_d.delete();
      ready_viol = 0;
      stab_viol  = 0;
      model_expect();
      @(negedge clk);
      pulse_start();
      foreach (stream[i]) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         if (poke_start && i == 4) pulse_start();
         send_byte(stream[i], ok);
         if (!ok) break;
      end
      wait_done(name);
      checks++;
      if (err !== exp_err) begin
         failures++;
         $display("FAIL %s err got=%b want=%b", name, err, exp_err);
      end
      checks++;
      if (cpu_rst !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s cpu_rst/busy got=%b/%b want=0/0", name, cpu_rst, busy);
      end
      checks++;
      if (got_a.size() != exp_a.size()) begin
         failures++;
         $display("FAIL %s write_count got=%0d want=%0d", name, got_a.size(), exp_a.size());
      end else begin
         foreach (exp_a[i]) begin
            checks++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
               failures++;
               $display("FAIL %s write%0d got=%0d:%08h want=%0d:%08h",
                        name, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
            end
         end
      end
      checks++;
      if (ready_viol != 0 || stab_viol != 0) begin
         failures++;
         $display("FAIL %s ready_in_write/unstable_wa_wd got=%0d/%0d want=0/0",
                  name, ready_viol, stab_viol);
      end
      $display("load %s: N=%0d writes=%0d err=%b", name,
               int'({stream[1], stream[0]}), got_a.size(), err);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;          // reset must win over start
      byte_valid = 1'b1;
      byte_data = 8'hA5;
      repeat (3) @(negedge clk);
      start = 1'b0;
      byte_valid = 1'b0;
      rst = 1'b0;
      checks++;
      if ({we, wa, wd} !== '0 || byte_ready !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || err !== 1'b0 || cpu_rst !== 1'b1) begin
         failures++;
         $display("FAIL reset_state got we=%b wa=%0d wd=%08h rdy=%b busy=%b done=%b err=%b cpu_rst=%b want 0/0/0/0/0/0/0/1",
                  we, wa, wd, byte_ready, busy, done, err, cpu_rst);
      end
      $display("reset applied");
   endtask

   task automatic test_single_word();
      stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(8'h13);
`endif
      run_load("single_word", 0, 1'b0);
      checks++;
      if (got_d.size() != 1 || got_d[0] !== 32'h0000_0013 || got_a[0] !== '0) begin
         failures++;
         $display("FAIL single_word_const got=%0d writes wd=%08h want=1 writes wd=00000013",
                  got_d.size(), wd);
      end
   endtask

   task automatic test_gaps();
      make_stream(2, 1'b0);
      run_load("two_words_gaps", 3, 1'b0);
   endtask

   task automatic test_zero_len();
      stream = '{8'h00, 8'h00};
      run_load("zero_len", 1, 1'b0);
   endtask

   task automatic test_reset_mid();
      bit ok;
      got_a.delete();
      make_stream(2, 1'b0);
      @(negedge clk);
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(stream[i], ok);
      // Reset lands while a third data byte is being offered.
      byte_valid = 1'b1;
      byte_data  = 8'hEE;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1 || got_a.size() != 0) begin
         failures++;
         $display("FAIL reset_mid got busy=%b done=%b cpu_rst=%b writes=%0d want 0/0/1/0",
                  busy, done, cpu_rst, got_a.size());
      end
      $display("reset mid-load applied");
      make_stream(2, 1'b0);
      run_load("after_reset", 1, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         make_stream($urandom_range(1, 9), 1'($urandom_range(0, 1)));
         run_load($sformatf("random%0d", k), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_restart();
      bit ok;
      stream = '{8'h01, 8'h04};   // N=1025 -> error
      run_load("n_1025", 0, 1'b0);
      pulse_start();
      checks++;
      if (done !== 1'b0 || err !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL restart got done=%b err=%b cpu_rst=%b busy=%b want 0/0/1/1",
                  done, err, cpu_rst, busy);
      end
      $display("restart from done");
      send_byte(8'h00, ok);
      send_byte(8'h00, ok);
      wait_done("restart_finish");
   endtask

   task automatic test_full_depth();
      make_stream(DEPTH, 1'b0);
      run_load("full_depth", 0, 1'b0);
      checks++;
      if (got_a.size() == 0 || got_a[got_a.size()-1] !== AW'(DEPTH - 1)) begin
         failures++;
         $display("FAIL full_depth_last_wa got=%0d want=%0d",
                  (got_a.size() == 0) ? -1 : int'(got_a[got_a.size()-1]), DEPTH - 1);
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      run_load("chk_good", 0, 1'b0);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL chk_good_const got=%b want=0", err);
      end
      stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
      run_load("chk_bad", 0, 1'b0);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL chk_bad_const got=%b want=1", err);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      start = 1'b0;
      byte_valid = 1'b0;
      byte_data = 8'd0;
      test_reset();
      test_single_word();
      test_gaps();
      test_zero_len();
      test_reset_mid();
      test_random();
      test_restart();
      test_full_depth();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
